// File: rtl/mips_defs.sv
// Shared MIPS definitions: memory opcodes, access-size encoding, reset PC
// and a small decoder used by the M-stage datapath.
package mips_defs;

    // Memory-access opcodes (IMcode[31:26])
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    // Access size of a load/store
    typedef enum logic [1:0] {
        SZ_W = 2'd0,
        SZ_H = 2'd1,
        SZ_B = 2'd2
    } size_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // Decoded view of one memory instruction
    typedef struct packed {
        logic  is_load;
        logic  is_store;
        size_t size;
        logic  sgn;
    } mem_op_t;

    // Classify an opcode; anything not listed is neither load nor store
    function automatic mem_op_t decode_mem_op(input logic [5:0] op);
        mem_op_t d;
        d.is_load  = 1'b0;
        d.is_store = 1'b0;
        d.size     = SZ_W;
        d.sgn      = 1'b0;
        case (op)
            OP_LW:  begin d.is_load = 1'b1;  d.size = SZ_W;                 end
            OP_LH:  begin d.is_load = 1'b1;  d.size = SZ_H; d.sgn = 1'b1;   end
            OP_LHU: begin d.is_load = 1'b1;  d.size = SZ_H;                 end
            OP_LB:  begin d.is_load = 1'b1;  d.size = SZ_B; d.sgn = 1'b1;   end
            OP_LBU: begin d.is_load = 1'b1;  d.size = SZ_B;                 end
            OP_SW:  begin d.is_store = 1'b1; d.size = SZ_W;                 end
            OP_SH:  begin d.is_store = 1'b1; d.size = SZ_H;                 end
            OP_SB:  begin d.is_store = 1'b1; d.size = SZ_B;                 end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dm_ext.sv
// Load lane select plus sign/zero extension (purely combinational).
module dm_ext
    import mips_defs::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] ext
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Pick the addressed halfword/byte and extend it to 32 bits
    always_comb begin
        half_sel = lane[1] ? word[31:16] : word[15:0];
        byte_sel = word[{lane, 3'b000} +: 8];
        case (size)
            SZ_H:    ext = {{16{sgn & half_sel[15]}}, half_sel};
            SZ_B:    ext = {{24{sgn & byte_sel[7]}}, byte_sel};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/dm_stage.sv
// M-stage datapath: decodes loads/stores, owns the data memory, performs
// byte-enabled stores on the clock edge and combinational extended reads.
// Address errors are flagged for CP0; erroneous stores never commit.
module dm_stage
    import mips_defs::*;
#(
    parameter int          DM_WORDS = 1024,
    parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] IMcode_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] WD_M,
    output logic [31:0] DO_M,
    output logic        AdEL_M,
    output logic        AdES_M,
    output logic        WE_trace,
    output logic [31:0] WA_trace,
    output logic [31:0] WDat_trace
);

    localparam int          IDX_W    = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(DM_WORDS) << 2;

    logic [31:0] mem_q [DM_WORDS];

    mem_op_t          dec;
    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             in_range;
    logic             misaligned;
    logic             bad_addr;
    logic [31:0]      rd_word;
    logic [31:0]      ext_val;

    logic [3:0]       be;
    logic [31:0]      wr_lanes;
    logic [31:0]      merged;
    logic             we_d;

    logic             we_trace_d,   we_trace_q;
    logic [31:0]      wa_trace_d,   wa_trace_q;
    logic [31:0]      wdat_trace_d, wdat_trace_q;

    // PC is only carried for tracing upstream; fold unused bits away
    logic unused_bits;
    assign unused_bits = ^{PC_M, IMcode_M[25:0], off};

    // Decode the instruction and qualify the address
    always_comb begin
        dec      = decode_mem_op(IMcode_M[31:26]);
        off      = AO_M - DM_BASE;
        idx      = off[IDX_W+1:2];
        lane     = AO_M[1:0];
        in_range = (off < DM_BYTES);
        case (dec.size)
            SZ_W:    misaligned = (lane != 2'b00);
            SZ_H:    misaligned = lane[0];
            default: misaligned = 1'b0;
        endcase
        bad_addr = misaligned | ~in_range;
        AdEL_M   = ~Reset & dec.is_load  & bad_addr;
        AdES_M   = ~Reset & dec.is_store & bad_addr;
        rd_word  = mem_q[idx];
    end

    dm_ext u_ext (
        .word (rd_word),
        .lane (lane),
        .size (dec.size),
        .sgn  (dec.sgn),
        .ext  (ext_val)
    );

    // Load result is forced to zero for non-loads, faulting loads and reset
    always_comb begin
        DO_M = (Reset | ~dec.is_load | AdEL_M) ? 32'h0 : ext_val;
    end

    // Byte enables, replicated store data and the merged word to write back
    always_comb begin
        be       = 4'b0000;
        wr_lanes = WD_M;
        case (dec.size)
            SZ_W: be = 4'b1111;
            SZ_H: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{WD_M[15:0]}};
            end
            SZ_B: begin
                be       = 4'b0001 << lane;
                wr_lanes = {4{WD_M[7:0]}};
            end
            default: ;
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? wr_lanes[8*b +: 8] : rd_word[8*b +: 8];
        end
        we_d = dec.is_store & ~AdES_M & ~Reset;
    end

    // Next trace values: address/data only move when a store commits
    always_comb begin
        we_trace_d   = we_d;
        wa_trace_d   = we_d ? (DM_BASE + (32'(idx) << 2)) : wa_trace_q;
        wdat_trace_d = we_d ? merged : wdat_trace_q;
    end

    // Data memory: cleared on reset, one merged word written per store
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (we_d) begin
            mem_q[idx] <= merged;
        end
    end

    // Write-trace registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            we_trace_q   <= 1'b0;
            wa_trace_q   <= 32'h0;
            wdat_trace_q <= 32'h0;
        end else begin
            we_trace_q   <= we_trace_d;
            wa_trace_q   <= wa_trace_d;
            wdat_trace_q <= wdat_trace_d;
        end
    end

    assign WE_trace   = we_trace_q;
    assign WA_trace   = wa_trace_q;
    assign WDat_trace = wdat_trace_q;

endmodule

// File: tb/tb_dm_stage.sv
// Bench for dm_stage: a byte-addressed memory model predicts load results,
// address flags and the write trace for directed and random instructions.
module tb_dm_stage;

    localparam int          DM_WORDS = 1024;
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam int          NBYTES   = 4 * DM_WORDS;

    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
    localparam logic [5:0] ADDU = 6'b000000, ORI = 6'b001101;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] imcode, pc, ao, wd;
    logic [31:0] do_m, wa_tr, wdat_tr;
    logic        adel, ades, we_tr;

    dm_stage #(.DM_WORDS(DM_WORDS), .DM_BASE(DM_BASE)) dut (
        .CLK        (clk),
        .Reset      (reset),
        .IMcode_M   (imcode),
        .PC_M       (pc),
        .AO_M       (ao),
        .WD_M       (wd),
        .DO_M       (do_m),
        .AdEL_M     (adel),
        .AdES_M     (ades),
        .WE_trace   (we_tr),
        .WA_trace   (wa_tr),
        .WDat_trace (wdat_tr)
    );

    // ---------------- model state ----------------
    logic [7:0]  m_bytes [NBYTES];
    logic        exp_we;
    logic [31:0] exp_wa, exp_wdat;

    int vec_count = 0;
    int err_count = 0;

    // values sampled in the last step, for literal pins
    logic [31:0] s_do;
    logic        s_adel, s_ades, s_we;
    logic [31:0] s_wa, s_wdat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Size in bytes of an access; 0 when not a memory op
    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            LW, SW:       return 4;
            LH, LHU, SH:  return 2;
            LB, LBU, SB:  return 1;
            default:      return 0;
        endcase
    endfunction

    // ---------------- driver + scoreboard step ----------------
    // Called at posedge+1: drives one instruction for one cycle, checks the
    // combinational outputs mid-cycle and the trace just after the edge.
    task automatic step(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d, input bit rst);
        int          n;
        bit          is_ld, is_st, sgn, bad, wr;
        logic [31:0] off, val, e_do, base;
        logic [7:0]  newb [4];

        reset  = rst;
        imcode = {op, 26'($urandom)};
        pc     = $urandom;
        ao     = a;
        wd     = d;

        n     = op_bytes(op);
        is_ld = (op == LW || op == LH || op == LHU || op == LB || op == LBU);
        is_st = (op == SW || op == SH || op == SB);
        sgn   = (op == LH || op == LB);
        off   = a - DM_BASE;
        bad   = (off >= NBYTES) || (n != 0 && (a % n) != 0);

        e_do = 32'h0;
        if (!rst && is_ld && !bad) begin
            val = 32'h0;
            for (int i = 0; i < n; i++) val |= 32'(m_bytes[off + i]) << (8 * i);
            if (sgn && n == 2 && val[15]) val |= 32'hFFFF_0000;
            if (sgn && n == 1 && val[7])  val |= 32'hFFFF_FF00;
            e_do = val;
        end
        wr = !rst && is_st && !bad;

        #3;
        s_do = do_m; s_adel = adel; s_ades = ades;
        check("DO_M",   do_m, e_do);
        check("AdEL_M", 32'(adel), 32'(!rst && is_ld && bad));
        check("AdES_M", 32'(ades), 32'(!rst && is_st && bad));

        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) m_bytes[i] = 8'h00;
            exp_we = 1'b0; exp_wa = 32'h0; exp_wdat = 32'h0;
        end else if (wr) begin
            base = off & ~32'h3;
            for (int i = 0; i < n; i++) m_bytes[off + i] = d[8*i +: 8];
            for (int j = 0; j < 4; j++) newb[j] = m_bytes[base + j];
            exp_we   = 1'b1;
            exp_wa   = DM_BASE + base;
            exp_wdat = {newb[3], newb[2], newb[1], newb[0]};
        end else begin
            exp_we = 1'b0;
        end
        s_we = we_tr; s_wa = wa_tr; s_wdat = wdat_tr;
        check("WE_trace",   32'(we_tr), 32'(exp_we));
        check("WA_trace",   wa_tr,   exp_wa);
        check("WDat_trace", wdat_tr, exp_wdat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ops [10];
        logic [5:0] op;
        logic [31:0] a;
        int r;
        ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, ADDU, ORI};

        reset = 1'b1; imcode = 32'h0; pc = 32'h3000; ao = 32'h0; wd = 32'h0;
        exp_we = 1'b0; exp_wa = 32'h0; exp_wdat = 32'h0;
        for (int i = 0; i < NBYTES; i++) m_bytes[i] = 8'h00;
        @(posedge clk);
        #1;

        // directed sequence with hand-computed pins
        step(LW, 32'h0, 32'h0, 1'b1);
        check("pin_rst_we", 32'(s_we), 32'h0);
        step(LW, 32'h0, 32'h0, 1'b0);
        check("pin_lw0_do", s_do, 32'h0);
        check("pin_lw0_adel", 32'(s_adel), 32'h0);
        step(SW, 32'h10, 32'h8765_4321, 1'b0);
        check("pin_sw_we",   32'(s_we), 32'h1);
        check("pin_sw_wa",   s_wa,   32'h10);
        check("pin_sw_wdat", s_wdat, 32'h8765_4321);
        step(LW,  32'h10, 32'h0, 1'b0); check("pin_lw10",  s_do, 32'h8765_4321);
        step(LB,  32'h13, 32'h0, 1'b0); check("pin_lb13",  s_do, 32'hFFFF_FF87);
        step(LBU, 32'h13, 32'h0, 1'b0); check("pin_lbu13", s_do, 32'h0000_0087);
        step(LH,  32'h12, 32'h0, 1'b0); check("pin_lh12",  s_do, 32'hFFFF_8765);
        step(LHU, 32'h10, 32'h0, 1'b0); check("pin_lhu10", s_do, 32'h0000_4321);
        step(SB,  32'h11, 32'h1234_56AA, 1'b0); check("pin_sb_wdat", s_wdat, 32'h8765_AA21);
        step(SH,  32'h12, 32'hFFFF_1234, 1'b0); check("pin_sh_wdat", s_wdat, 32'h1234_AA21);
        step(SW,  32'h12, 32'hCAFE_F00D, 1'b0);
        check("pin_sw_mis_ades", 32'(s_ades), 32'h1);
        check("pin_sw_mis_we",   32'(s_we),   32'h0);
        step(LW,  32'h10, 32'h0, 1'b0); check("pin_word_kept", s_do, 32'h1234_AA21);
        step(LH,  32'h11, 32'h0, 1'b0);
        check("pin_lh_mis_adel", 32'(s_adel), 32'h1);
        check("pin_lh_mis_do",   s_do, 32'h0);
        step(LW,  32'h1000, 32'h0, 1'b0);
        check("pin_lw_oor_adel", 32'(s_adel), 32'h1);
        check("pin_lw_oor_do",   s_do, 32'h0);
        step(SW,  32'h20, 32'hDEAD_BEEF, 1'b1);
        check("pin_rst_sw_we", 32'(s_we), 32'h0);
        step(LW,  32'h20, 32'h0, 1'b0); check("pin_lw20", s_do, 32'h0);
        step(ADDU, 32'h20, 32'h5555_5555, 1'b0);
        check("pin_addu_do",   s_do, 32'h0);
        check("pin_addu_flag", 32'({s_adel, s_ades}), 32'h0);
        check("pin_addu_we",   32'(s_we), 32'h0);

        // randomized traffic, concentrated on a small window for reuse
        for (int k = 0; k < 3000; k++) begin
            op = ops[$urandom_range(0, 9)];
            r  = $urandom_range(0, 9);
            if (r <= 6)      a = 32'($urandom_range(0, 127));
            else if (r == 7) a = 32'($urandom_range(0, NBYTES - 1));
            else if (r == 8) a = 32'(NBYTES) + 32'($urandom_range(0, 64));
            else             a = $urandom;
            step(op, a, $urandom, ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
